// File: rtl/arm_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// arm_ctrl_fsm_if
//   Bundle between the ARM-style control unit and its surroundings
//   (instruction issue, ALU, register file, memory and branch unit).
//   slave  : the control unit (arm_ctrl_fsm)
//   master : the environment driving instructions and returning ALU/memory status
// Signals
//   instr[31:0], instr_valid, instr_ready   instruction handshake
//   alu_cpsr[31:0]                          ALU flags, [31:28] = NZCV
//   mem_ack                                 memory completed current LDR/STR
//   alu_ctl[10:0], rn/rm/rd_addr, imm8,     decoded ALU / register-file controls
//   imm_en, cpsr_en, reg_we
//   mem_re, mem_we                          memory requests, held in MEM
//   br_taken, br_offset[23:0], link_we      branch requests, pulsed in WB
//   nzcv[3:0]                               architectural flags
//   done, cond_fail, mem_err                retirement status, pulsed in WB
// ----------------------------------------------------------------------------
interface arm_ctrl_fsm_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_cpsr;
    logic        mem_ack;
    logic [10:0] alu_ctl;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rd_addr;
    logic [7:0]  imm8;
    logic        imm_en;
    logic        cpsr_en;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        br_taken;
    logic [23:0] br_offset;
    logic        link_we;
    logic [3:0]  nzcv;
    logic        done;
    logic        cond_fail;
    logic        mem_err;

    modport master (
        output instr, instr_valid, alu_cpsr, mem_ack,
        input  instr_ready, alu_ctl, rn_addr, rm_addr, rd_addr, imm8, imm_en, cpsr_en,
               reg_we, mem_re, mem_we, br_taken, br_offset, link_we, nzcv, done,
               cond_fail, mem_err
    );

    modport slave (
        input  instr, instr_valid, alu_cpsr, mem_ack,
        output instr_ready, alu_ctl, rn_addr, rm_addr, rd_addr, imm8, imm_en, cpsr_en,
               reg_we, mem_re, mem_we, br_taken, br_offset, link_we, nzcv, done,
               cond_fail, mem_err
    );
endinterface

// File: rtl/arm_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// arm_ctrl_fsm
//   Multi-cycle control unit for an ARM-style datapath. Accepts one instruction
//   per handshake in IDLE, decodes it in DECODE (condition checked against NZCV),
//   drives the ALU in EXEC, waits for memory in MEM (LDR/STR only, with timeout)
//   and retires in WB. Owns the NZCV register, loaded from the ALU flags.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : arm_ctrl_fsm_if.slave (handshake, ALU, memory, branch, status)
// Parameters
//   MEM_TIMEOUT : max cycles spent in MEM waiting for mem_ack (>= 1)
//   CNT_W       : width of the MEM wait counter (must hold MEM_TIMEOUT)
// ----------------------------------------------------------------------------
module arm_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    arm_ctrl_fsm_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    localparam logic [10:0] CTL_ADD = 11'd0;
    localparam logic [10:0] CTL_SUB = 11'd2;
    localparam logic [10:0] CTL_AND = 11'd3;
    localparam logic [10:0] CTL_ORR = 11'd4;
    localparam logic [10:0] CTL_EOR = 11'd5;
    localparam logic [10:0] CTL_MOV = 11'd6;
    localparam logic [10:0] CTL_MVN = 11'd7;
    localparam logic [10:0] CTL_CMP = 11'd8;
    localparam logic [10:0] CTL_TST = 11'd9;
    localparam logic [10:0] CTL_TEQ = 11'd10;
    localparam logic [10:0] CTL_BIC = 11'd11;
    localparam logic [10:0] CTL_B   = 11'd31;
    localparam logic [10:0] CTL_BL  = 11'd32;
    localparam logic [10:0] CTL_LDR = 11'd41;
    localparam logic [10:0] CTL_STR = 11'd42;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [31:0]      r_instr;
    logic [10:0]      r_alu_ctl;
    logic [3:0]       r_rn;
    logic [3:0]       r_rm;
    logic [3:0]       r_rd;
    logic [7:0]       r_imm8;
    logic             r_imm_en;
    logic             r_flag_set;
    logic             r_wr_pend;
    logic             r_is_mem;
    logic             r_is_load;
    logic             r_is_br;
    logic             r_is_link;
    logic [23:0]      r_br_offset;
    logic [3:0]       r_nzcv;
    logic             r_cond_fail;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_nop;
    logic [10:0]      w_ctl;
    logic             w_test_op;
    logic             w_cond_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    // N=f[3] Z=f[2] C=f[1] V=f[0]
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic res;
        unique case (c)
            4'b0000: res = f[2];
            4'b0001: res = !f[2];
            4'b0010: res = f[1];
            4'b0011: res = !f[1];
            4'b0100: res = f[3];
            4'b0101: res = !f[3];
            4'b0110: res = f[0];
            4'b0111: res = !f[0];
            4'b1000: res = f[1] && !f[2];
            4'b1001: res = !f[1] || f[2];
            4'b1010: res = (f[3] == f[0]);
            4'b1011: res = (f[3] != f[0]);
            4'b1100: res = !f[2] && (f[3] == f[0]);
            4'b1101: res = f[2] || (f[3] != f[0]);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Decode of the latched instruction; consumed only in DECODE.
    always_comb begin
        w_nop     = 1'b0;
        w_ctl     = CTL_ADD;
        w_test_op = 1'b0;
        unique case (r_instr[27:26])
            2'b00: begin
                unique case (r_instr[24:21])
                    4'b0000: w_ctl = CTL_AND;
                    4'b0001: w_ctl = CTL_EOR;
                    4'b0010: w_ctl = CTL_SUB;
                    4'b0100: w_ctl = CTL_ADD;
                    4'b1000: begin w_ctl = CTL_TST; w_test_op = 1'b1; end
                    4'b1001: begin w_ctl = CTL_TEQ; w_test_op = 1'b1; end
                    4'b1010: begin w_ctl = CTL_CMP; w_test_op = 1'b1; end
                    4'b1100: w_ctl = CTL_ORR;
                    4'b1101: w_ctl = CTL_MOV;
                    4'b1110: w_ctl = CTL_BIC;
                    4'b1111: w_ctl = CTL_MVN;
                    default: w_nop = 1'b1;
                endcase
            end
            2'b01:   w_ctl = r_instr[20] ? CTL_LDR : CTL_STR;
            2'b10:   w_ctl = r_instr[24] ? CTL_BL : CTL_B;
            default: w_nop = 1'b1;
        endcase
    end

    assign w_cond_ok = cond_pass(r_instr[31:28], r_nzcv);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.instr_valid) w_state_next = ST_DECODE;
            // Failed condition and NOPs retire without touching the datapath.
            ST_DECODE: w_state_next = (!w_cond_ok || w_nop) ? ST_WB : ST_EXEC;
            ST_EXEC:   w_state_next = r_is_mem ? ST_MEM : ST_WB;
            ST_MEM:    if (bus.mem_ack || w_timeout) w_state_next = ST_WB;
            ST_WB:     w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_alu_ctl   <= '0;
            r_rn        <= '0;
            r_rm        <= '0;
            r_rd        <= '0;
            r_imm8      <= '0;
            r_imm_en    <= 1'b0;
            r_flag_set  <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_is_mem    <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_br     <= 1'b0;
            r_is_link   <= 1'b0;
            r_br_offset <= '0;
            r_nzcv      <= '0;
            r_cond_fail <= 1'b0;
            r_mem_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) r_instr <= bus.instr;
                end
                ST_DECODE: begin
                    r_cond_fail <= !w_cond_ok;
                    if (w_cond_ok && !w_nop) begin
                        r_alu_ctl  <= w_ctl;
                        r_rn       <= r_instr[19:16];
                        r_rd       <= r_instr[15:12];
                        r_rm       <= r_instr[3:0];
                        r_imm8     <= r_instr[7:0];
                        r_imm_en   <= (r_instr[27:26] == 2'b00) && r_instr[25];
                        r_flag_set <= (r_instr[27:26] == 2'b00) && (r_instr[20] || w_test_op);
                        r_wr_pend  <= ((r_instr[27:26] == 2'b00) && !w_test_op) ||
                                      ((r_instr[27:26] == 2'b01) && r_instr[20]);
                        r_is_mem   <= (r_instr[27:26] == 2'b01);
                        r_is_load  <= (r_instr[27:26] == 2'b01) && r_instr[20];
                        r_is_br    <= (r_instr[27:26] == 2'b10);
                        r_is_link  <= (r_instr[27:26] == 2'b10) && r_instr[24];
                        if (r_instr[27:26] == 2'b10) r_br_offset <= r_instr[23:0];
                    end
                end
                ST_EXEC: begin
                    r_cnt <= '0;
                    if (r_flag_set) r_nzcv <= bus.alu_cpsr[31:28];
                end
                ST_MEM: begin
                    r_cnt <= w_cnt_inc;
                    // An ack arriving on the last allowed cycle still wins.
                    if (!bus.mem_ack && w_timeout) r_mem_err <= 1'b1;
                end
                ST_WB: begin
                    r_alu_ctl   <= '0;
                    r_rn        <= '0;
                    r_rm        <= '0;
                    r_rd        <= '0;
                    r_imm8      <= '0;
                    r_imm_en    <= 1'b0;
                    r_flag_set  <= 1'b0;
                    r_wr_pend   <= 1'b0;
                    r_is_mem    <= 1'b0;
                    r_is_load   <= 1'b0;
                    r_is_br     <= 1'b0;
                    r_is_link   <= 1'b0;
                    r_br_offset <= '0;
                    r_cond_fail <= 1'b0;
                    r_mem_err   <= 1'b0;
                    r_cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == ST_IDLE);
    assign bus.alu_ctl     = r_alu_ctl;
    assign bus.rn_addr     = r_rn;
    assign bus.rm_addr     = r_rm;
    assign bus.rd_addr     = r_rd;
    assign bus.imm8        = r_imm8;
    assign bus.imm_en      = r_imm_en;
    assign bus.cpsr_en     = (r_state == ST_EXEC) && r_flag_set;
    assign bus.reg_we      = (r_state == ST_WB) && r_wr_pend && !r_mem_err;
    assign bus.mem_re      = (r_state == ST_MEM) && r_is_load;
    assign bus.mem_we      = (r_state == ST_MEM) && r_is_mem && !r_is_load;
    assign bus.br_taken    = (r_state == ST_WB) && r_is_br;
    assign bus.br_offset   = r_br_offset;
    assign bus.link_we     = (r_state == ST_WB) && r_is_link;
    assign bus.nzcv        = r_nzcv;
    assign bus.done        = (r_state == ST_WB);
    assign bus.cond_fail   = (r_state == ST_WB) && r_cond_fail;
    assign bus.mem_err     = (r_state == ST_WB) && r_mem_err;

endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_arm_ctrl_fsm
//   Scoreboard bench: each issued instruction pushes its expected retirement
//   record; a negedge monitor pops and compares when done pulses. Latency,
//   EXEC-cycle controls and memory request lengths are compared inline.
// ----------------------------------------------------------------------------
module tb_arm_ctrl_fsm;

    localparam int unsigned MemTimeout = 16;

    typedef struct {
        string       name;
        logic        reg_we;
        logic        br_taken;
        logic [23:0] br_offset;
        logic        link_we;
        logic        cond_fail;
        logic        mem_err;
        logic [3:0]  nzcv;
    } retire_t;

    logic clk;
    logic rst_n;
    arm_ctrl_fsm_if bus ();

    arm_ctrl_fsm #(
        .MEM_TIMEOUT (MemTimeout),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    retire_t     sb_q[$];
    logic [3:0]  m_nzcv;

    // Values observed by exec_instr
    int          g_lat;
    int          g_mem_cycles;
    logic [10:0] g_ctl;
    logic [7:0]  g_imm8;
    logic        g_imm_en;
    logic        g_cpsr_en;
    logic [3:0]  g_rd;
    logic [3:0]  g_rn;
    logic [3:0]  g_rm;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_retire(input string name, input logic rw, input logic bt,
                                 input logic [23:0] off, input logic lw, input logic cf,
                                 input logic me);
        retire_t r;
        r.name      = name;
        r.reg_we    = rw;
        r.br_taken  = bt;
        r.br_offset = off;
        r.link_we   = lw;
        r.cond_fail = cf;
        r.mem_err   = me;
        r.nzcv      = m_nzcv;
        sb_q.push_back(r);
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    retire_t r;
                    r = sb_q.pop_front();
                    check_eq({r.name, ".reg_we"},    32'(bus.reg_we),    32'(r.reg_we));
                    check_eq({r.name, ".br_taken"},  32'(bus.br_taken),  32'(r.br_taken));
                    check_eq({r.name, ".link_we"},   32'(bus.link_we),   32'(r.link_we));
                    check_eq({r.name, ".cond_fail"}, 32'(bus.cond_fail), 32'(r.cond_fail));
                    check_eq({r.name, ".mem_err"},   32'(bus.mem_err),   32'(r.mem_err));
                    check_eq({r.name, ".nzcv"},      32'(bus.nzcv),      32'(r.nzcv));
                    if (r.br_taken)
                        check_eq({r.name, ".br_offset"}, 32'(bus.br_offset), 32'(r.br_offset));
                end
            end else begin
                check_eq("stray_pulse", 32'({bus.reg_we, bus.br_taken, bus.link_we,
                                             bus.cond_fail, bus.mem_err}), 32'd0);
            end
        end
    end

    // Issue one instruction and follow it to retirement. ack_at = MEM cycle on which
    // mem_ack is raised (0 = never).
    task automatic exec_instr(input logic [31:0] ins, input logic [31:0] cpsr, input int ack_at);
        int cyc;
        cyc = 0;
        while (!bus.instr_ready && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_wait", 32'(bus.instr_ready), 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.alu_cpsr    = cpsr;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom();
        g_lat        = 1;
        g_mem_cycles = 0;
        while (!bus.done && g_lat < 64) begin
            if (bus.mem_re || bus.mem_we) begin
                g_mem_cycles++;
                bus.mem_ack = (g_mem_cycles == ack_at);
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (g_lat == 2) begin
                g_ctl     = bus.alu_ctl;
                g_imm8    = bus.imm8;
                g_imm_en  = bus.imm_en;
                g_cpsr_en = bus.cpsr_en;
                g_rd      = bus.rd_addr;
                g_rn      = bus.rn_addr;
                g_rm      = bus.rm_addr;
            end
            @(negedge clk);
            g_lat++;
        end
        bus.mem_ack = 1'b0;
        check_eq("done_seen", 32'(bus.done), 32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        m_nzcv          = 4'b0000;
        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.alu_cpsr    = '0;
        bus.mem_ack     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.instr_ready), 32'd1);
        check_eq("rst_nzcv",  32'(bus.nzcv), 32'd0);
        check_eq("rst_outs",  32'({bus.done, bus.reg_we, bus.mem_re, bus.mem_we,
                                   bus.br_taken, bus.cpsr_en, bus.alu_ctl}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDS R2,R1,#5
        m_nzcv = 4'b0100;
        expect_retire("adds", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE291_2005, 32'h4000_0000, 0);
        check_eq("adds.lat",     32'(g_lat), 32'd3);
        check_eq("adds.ctl",     32'(g_ctl), 32'd0);
        check_eq("adds.imm_en",  32'(g_imm_en), 32'd1);
        check_eq("adds.imm8",    32'(g_imm8), 32'd5);
        check_eq("adds.cpsr_en", 32'(g_cpsr_en), 32'd1);
        check_eq("adds.rd",      32'(g_rd), 32'd2);
        check_eq("adds.rn",      32'(g_rn), 32'd1);
        @(negedge clk);
        check_eq("idle_ctl",     32'(bus.alu_ctl), 32'd0);
        check_eq("idle_imm8",    32'(bus.imm8), 32'd0);

        // MOVS R3,#1 -> C only
        m_nzcv = 4'b0010;
        expect_retire("movs", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE3B0_3001, 32'h2000_0000, 0);
        check_eq("movs.ctl", 32'(g_ctl), 32'd6);

        // CMP R1,R2 -> Z and C
        m_nzcv = 4'b0110;
        expect_retire("cmp_z", 0, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE151_0002, 32'h6000_0000, 0);
        check_eq("cmp.ctl",     32'(g_ctl), 32'd8);
        check_eq("cmp.cpsr_en", 32'(g_cpsr_en), 32'd1);
        check_eq("cmp.rm",      32'(g_rm), 32'd2);

        // BEQ taken; ALU flags on the bus must not leak into nzcv
        expect_retire("beq_t", 0, 1, 24'h000010, 0, 0, 0);
        exec_instr(32'h0A00_0010, 32'hF000_0000, 0);
        check_eq("beq_t.lat", 32'(g_lat), 32'd3);
        check_eq("beq_t.ctl", 32'(g_ctl), 32'd31);

        // BLNE with Z=1 -> skipped
        expect_retire("blne_f", 0, 0, 24'h0, 0, 1, 0);
        exec_instr(32'h1B00_0020, 32'h0, 0);
        check_eq("blne_f.lat", 32'(g_lat), 32'd2);

        // CMP -> C only, then BEQ not taken
        m_nzcv = 4'b0010;
        expect_retire("cmp_c", 0, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE151_0002, 32'h2000_0000, 0);
        expect_retire("beq_f", 0, 0, 24'h0, 0, 1, 0);
        exec_instr(32'h0A00_0010, 32'h0, 0);
        check_eq("beq_f.lat", 32'(g_lat), 32'd2);

        // BL always
        expect_retire("bl", 0, 1, 24'h000ABC, 1, 0, 0);
        exec_instr(32'hEB00_0ABC, 32'h0, 0);
        check_eq("bl.ctl", 32'(g_ctl), 32'd32);

        // ADDHI without S: C&!Z true, flags unchanged
        expect_retire("addhi", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'h8085_4006, 32'hF000_0000, 0);
        check_eq("addhi.cpsr_en", 32'(g_cpsr_en), 32'd0);
        check_eq("addhi.imm_en",  32'(g_imm_en), 32'd0);

        // LDR with ack on third MEM cycle
        expect_retire("ldr", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE591_2000, 32'h0, 3);
        check_eq("ldr.ctl",  32'(g_ctl), 32'd41);
        check_eq("ldr.memc", 32'(g_mem_cycles), 32'd3);
        check_eq("ldr.lat",  32'(g_lat), 32'd6);

        // STR never acked -> timeout
        expect_retire("str_to", 0, 0, 24'h0, 0, 0, 1);
        exec_instr(32'hE581_2000, 32'h0, 0);
        check_eq("str.ctl",  32'(g_ctl), 32'd42);
        check_eq("str.memc", 32'(g_mem_cycles), MemTimeout);

        // LDR acked on the timeout cycle -> success
        expect_retire("ldr_edge", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE591_2000, 32'h0, MemTimeout);
        check_eq("ldr_edge.memc", 32'(g_mem_cycles), MemTimeout);

        // TST with S=0 still updates flags
        m_nzcv = 4'b1000;
        expect_retire("tst", 0, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE101_0002, 32'h8000_0000, 0);
        check_eq("tst.ctl",     32'(g_ctl), 32'd9);
        check_eq("tst.cpsr_en", 32'(g_cpsr_en), 32'd1);

        // RSB opcode -> NOP
        expect_retire("rsb_nop", 0, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE061_2003, 32'hF000_0000, 0);
        check_eq("rsb.lat", 32'(g_lat), 32'd2);

        // Condition 1111 -> never
        expect_retire("never", 0, 0, 24'h0, 0, 1, 0);
        exec_instr(32'hF291_2005, 32'hF000_0000, 0);

        // Undefined class -> NOP
        expect_retire("undef", 0, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hEC00_0000, 32'h0, 0);
        check_eq("undef.lat", 32'(g_lat), 32'd2);

        // N=1,V=0: LT passes, GE fails
        expect_retire("addlt", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hB085_4006, 32'h0, 0);
        expect_retire("addge", 0, 0, 24'h0, 0, 1, 0);
        exec_instr(32'hA085_4006, 32'h0, 0);

        // Async reset during EXEC: aborted, no retirement
        @(negedge clk);
        bus.instr       = 32'hE291_2005;
        bus.instr_valid = 1'b1;
        bus.alu_cpsr    = 32'h4000_0000;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst.cpsr_en", 32'(bus.cpsr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_nzcv = 4'b0000;
        check_eq("mid_rst.ready", 32'(bus.instr_ready), 32'd1);
        check_eq("mid_rst.nzcv",  32'(bus.nzcv), 32'd0);
        check_eq("mid_rst.outs",  32'({bus.done, bus.reg_we, bus.cpsr_en}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst.nzcv", 32'(bus.nzcv), 32'd0);

        // Normal operation resumes
        m_nzcv = 4'b0001;
        expect_retire("movs2", 1, 0, 24'h0, 0, 0, 0);
        exec_instr(32'hE3B0_3001, 32'h1000_0000, 0);
        check_eq("movs2.lat", 32'(g_lat), 32'd3);

        @(negedge clk);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
